// File: rtl/cpu_pkg.sv
// Shared fetch-side definitions: reset vector, bubble instruction, fetch FSM encoding
// and the pc/instruction pair carried from memory to decode.
package cpu_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } fetch_st_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_ent_t;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_skid_buf.sv
// Output register plus one pending entry between imem responses and decode; registered, 1-cycle.
// Input ready means the output slot is empty or drained this cycle; otherwise a response parks in pending.
module if_skid_buf
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_flush,
   input  logic        i_in_vld,
   input  fetch_ent_t  i_in_dat,
   output logic        o_in_rdy,
   output logic        o_out_vld,
   output logic [31:0] o_out_pc,
   output logic [31:0] o_out_inst,
   input  logic        i_out_rdy
);

   logic       r_out_vld;
   logic       r_pend_vld;
   fetch_ent_t r_out;
   fetch_ent_t r_pend;
   logic       w_take;
   logic       w_park;
   logic       w_pop;

   assign o_in_rdy = !r_out_vld || i_out_rdy;
   assign w_take   = i_in_vld && o_in_rdy;
   assign w_park   = i_in_vld && !o_in_rdy;
   assign w_pop    = r_out_vld && i_out_rdy;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_out_vld  <= 1'b0;
         r_pend_vld <= 1'b0;
         r_out.pc   <= RESET_PC;
         r_out.inst <= NOP_INST;
         r_pend     <= '0;
      end else if (i_flush) begin
         r_out_vld  <= 1'b0;
         r_pend_vld <= 1'b0;
      end else begin
         if (w_take) begin
            r_out     <= i_in_dat;
            r_out_vld <= 1'b1;
         end else if (w_pop) begin
            if (r_pend_vld) begin
               r_out      <= r_pend;
               r_pend_vld <= 1'b0;
            end else begin
               r_out_vld <= 1'b0;
            end
         end
         if (w_park) begin
            r_pend     <= i_in_dat;
            r_pend_vld <= 1'b1;
         end
      end
   end

   // pc keeps its last value while empty so decode sees a stable address
   assign o_out_vld  = r_out_vld;
   assign o_out_pc   = r_out.pc;
   assign o_out_inst = r_out_vld ? r_out.inst : NOP_INST;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: one outstanding imem request, gnt in N + rvalid in N+1 gives if_valid in N+2.
// Stalls requesting while decode holds a full output slot; redirects flush and drop in-flight data.
module if_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        id_ready,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst
);

   fetch_st_t   r_state;
   fetch_st_t   w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] w_pc_nxt;
   logic [31:0] r_req_pc;
   logic [31:0] w_req_pc_nxt;
   logic        r_drop;
   logic        w_drop_nxt;
   logic        w_rsp_vld;
   logic        w_slot_rdy;
   logic [31:0] w_redir_pc;
   fetch_ent_t  w_rsp_ent;

   assign w_redir_pc = word_align(redirect_pc);
   assign imem_addr  = r_pc;
   assign w_rsp_ent  = '{pc: r_req_pc, inst: imem_rdata};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= ST_REQ;
         r_pc     <= RESET_PC;
         r_req_pc <= RESET_PC;
         r_drop   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_pc     <= w_pc_nxt;
         r_req_pc <= w_req_pc_nxt;
         r_drop   <= w_drop_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_pc_nxt     = r_pc;
      w_req_pc_nxt = r_req_pc;
      w_drop_nxt   = r_drop;
      imem_req     = 1'b0;
      w_rsp_vld    = 1'b0;
      case (r_state)
         ST_REQ: begin
            imem_req = rst_n && w_slot_rdy;
            if (redirect_valid) begin
               w_pc_nxt = w_redir_pc;
               // an accepted request still returns data; mark it for discard
               if (imem_req && imem_gnt) begin
                  w_state_nxt = ST_WAIT;
                  w_drop_nxt  = 1'b1;
               end else begin
                  w_drop_nxt  = 1'b0;
               end
            end else if (imem_req && imem_gnt) begin
               w_req_pc_nxt = r_pc;
               w_state_nxt  = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (redirect_valid) begin
               w_pc_nxt = w_redir_pc;
               if (imem_rvalid) begin
                  w_state_nxt = ST_REQ;
                  w_drop_nxt  = 1'b0;
               end else begin
                  w_drop_nxt  = 1'b1;
               end
            end else if (imem_rvalid) begin
               w_state_nxt = ST_REQ;
               if (r_drop) begin
                  w_drop_nxt = 1'b0;
               end else begin
                  w_rsp_vld = 1'b1;
                  w_pc_nxt  = r_req_pc + 32'd4;
                  if (!w_slot_rdy) begin
                     w_state_nxt = ST_HOLD;
                  end
               end
            end
         end
         ST_HOLD: begin
            if (redirect_valid) begin
               w_pc_nxt    = w_redir_pc;
               w_state_nxt = ST_REQ;
               w_drop_nxt  = 1'b0;
            end else if (id_ready) begin
               w_state_nxt = ST_REQ;
            end
         end
         default: begin
            w_state_nxt = ST_REQ;
         end
      endcase
   end

   if_skid_buf #(
      .RESET_PC (RESET_PC),
      .NOP_INST (NOP_INST)
   ) u_skid (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_flush    (redirect_valid),
      .i_in_vld   (w_rsp_vld),
      .i_in_dat   (w_rsp_ent),
      .o_in_rdy   (w_slot_rdy),
      .o_out_vld  (if_valid),
      .o_out_pc   (if_pc),
      .o_out_inst (if_inst),
      .i_out_rdy  (id_ready)
   );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a one-cycle-latency instruction memory model
// whose response can be withheld per cycle.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        id_ready = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;

   int          n_tot = 0;
   int          n_bad = 0;
   bit          rsp_pend = 1'b0;
   logic [31:0] rsp_addr = '0;
   logic [31:0] gnt_log[$];
   logic [31:0] pc_log[$];
   logic [31:0] inst_log[$];

   localparam logic [31:0] NOP = 32'h0000_0013;

   always #5 clk = ~clk;

   if_stage dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_ready       (id_ready),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_inst        (if_inst)
   );

   function automatic logic [31:0] memw(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   // drive one cycle's inputs just after the edge and let them settle
   task automatic drv(input bit g, input bit rdy, input bit rsp_ok, input bit rd, input logic [31:0] rpc);
      imem_gnt       = g;
      id_ready       = rdy;
      redirect_valid = rd;
      redirect_pc    = rpc;
      imem_rvalid    = rsp_pend && rsp_ok;
      imem_rdata     = imem_rvalid ? memw(rsp_addr) : 32'hDEAD_BEEF;
      #1;
   endtask

   task automatic tick();
      if (imem_rvalid) rsp_pend = 1'b0;
      if (imem_req && imem_gnt) begin
         rsp_pend = 1'b1;
         rsp_addr = imem_addr;
         gnt_log.push_back(imem_addr);
      end
      if (if_valid && id_ready) begin
         pc_log.push_back(if_pc);
         inst_log.push_back(if_inst);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input bit keep_rsp);
      rst_n          = 1'b0;
      imem_gnt       = 1'b0;
      id_ready       = 1'b0;
      redirect_valid = 1'b0;
      imem_rvalid    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", imem_req, 0);
      chk("rst_vld", if_valid, 0);
      chk("rst_inst", if_inst, NOP);
      chk("rst_pc", if_pc, 32'h0);
      if (!keep_rsp) rsp_pend = 1'b0;
      gnt_log.delete();
      pc_log.delete();
      inst_log.delete();
      rst_n = 1'b1;
   endtask

   initial begin
      // zero-wait memory, decode always ready
      do_reset(0);
      for (int c = 0; c < 7; c++) begin
         drv(1, 1, 1, 0, 0);
         chk("t1_req", imem_req, (c % 2 == 0));
         chk("t1_vld", if_valid, (c >= 2 && c % 2 == 0));
         if (c == 3) chk("t1_nop", if_inst, NOP);
         tick();
      end
      chk("t1_ngnt", gnt_log.size(), 4);
      chk("t1_gnt0", gnt_log[0], 32'h0);
      chk("t1_gnt1", gnt_log[1], 32'h4);
      chk("t1_gnt2", gnt_log[2], 32'h8);
      chk("t1_ncons", pc_log.size(), 3);
      for (int i = 0; i < 3; i++) begin
         chk("t1_pc", pc_log[i], 32'(i * 4));
         chk("t1_inst", inst_log[i], 32'h5A5A_0000 + 32'(i * 4));
      end

      // decode stalls for 5 cycles while 0x4 arrives
      do_reset(0);
      for (int c = 0; c < 11; c++) begin
         drv(1, !(c >= 3 && c <= 7), 1, 0, 0);
         if (c >= 4 && c <= 7) begin
            chk("t2_noreq", imem_req, 0);
            chk("t2_vld", if_valid, 1);
            chk("t2_pc", if_pc, 32'h4);
         end
         tick();
      end
      chk("t2_ncons", pc_log.size(), 3);
      chk("t2_pc0", pc_log[0], 32'h0);
      chk("t2_pc1", pc_log[1], 32'h4);
      chk("t2_pc2", pc_log[2], 32'h8);
      chk("t2_inst1", inst_log[1], 32'h5A5A_0004);

      // redirect to 0x100 while waiting on the 0x8 response
      do_reset(0);
      for (int c = 0; c < 5; c++) begin
         drv(1, 1, 1, 0, 0);
         tick();
      end
      drv(1, 1, 0, 1, 32'h100);
      chk("t3_wait_req", imem_req, 0);
      tick();
      drv(1, 1, 1, 0, 0);
      chk("t3_drop_req", imem_req, 0);
      tick();
      drv(1, 1, 1, 0, 0);
      chk("t3_req", imem_req, 1);
      chk("t3_addr", imem_addr, 32'h100);
      chk("t3_vld", if_valid, 0);
      tick();
      drv(1, 1, 1, 0, 0);
      tick();
      drv(1, 1, 1, 0, 0);
      chk("t3_vld2", if_valid, 1);
      chk("t3_pc", if_pc, 32'h100);
      chk("t3_inst", if_inst, 32'h5A5A_0100);
      tick();
      chk("t3_ncons", pc_log.size(), 3);
      chk("t3_cons2", pc_log[2], 32'h100);

      // redirect to unaligned 0x203 in the same cycle as rvalid, then flush a live output
      do_reset(0);
      drv(1, 1, 1, 0, 0);
      tick();
      drv(1, 1, 1, 1, 32'h203);
      tick();
      drv(1, 1, 1, 0, 0);
      chk("t4_vld", if_valid, 0);
      chk("t4_addr", imem_addr, 32'h200);
      chk("t4_req", imem_req, 1);
      tick();
      drv(1, 1, 1, 0, 0);
      tick();
      drv(1, 0, 1, 1, 32'h40);
      chk("t4_vld2", if_valid, 1);
      chk("t4_pc", if_pc, 32'h200);
      chk("t4_inst", if_inst, 32'h5A5A_0200);
      chk("t4_stall_req", imem_req, 0);
      tick();
      drv(1, 1, 1, 0, 0);
      chk("t4_flush_vld", if_valid, 0);
      chk("t4_flush_inst", if_inst, NOP);
      chk("t4_flush_pc", if_pc, 32'h200);
      chk("t4_addr2", imem_addr, 32'h40);
      chk("t4_req2", imem_req, 1);
      tick();

      // redirect with gnt to 0xFFFF_FFFE, then pc wraps after the top word
      do_reset(0);
      drv(1, 1, 1, 1, 32'hFFFF_FFFE);
      tick();
      drv(1, 1, 1, 0, 0);
      chk("t5_wait_req", imem_req, 0);
      tick();
      drv(1, 1, 1, 0, 0);
      chk("t5_vld", if_valid, 0);
      chk("t5_addr", imem_addr, 32'hFFFF_FFFC);
      tick();
      drv(1, 1, 1, 0, 0);
      tick();
      drv(1, 1, 1, 0, 0);
      chk("t5_vld2", if_valid, 1);
      chk("t5_pc", if_pc, 32'hFFFF_FFFC);
      chk("t5_inst", if_inst, 32'hA5A5_FFFC);
      chk("t5_wrap", imem_addr, 32'h0);
      tick();

      // reset while stalled with a full output slot
      do_reset(0);
      for (int c = 0; c < 5; c++) begin
         drv(1, c <= 2, 1, 0, 0);
         tick();
      end
      do_reset(0);
      drv(1, 0, 1, 0, 0);
      chk("t6_vld", if_valid, 0);
      chk("t6_inst", if_inst, NOP);
      chk("t6_addr", imem_addr, 32'h0);
      chk("t6_req", imem_req, 1);
      tick();

      // reset while waiting; the stale response lands in the first cycle after release
      do_reset(0);
      for (int c = 0; c < 3; c++) begin
         drv(1, 1, 1, 0, 0);
         tick();
      end
      drv(1, 1, 0, 0, 0);
      tick();
      do_reset(1);
      drv(1, 1, 1, 0, 0);
      chk("t7_stale_rv", imem_rvalid, 1);
      chk("t7_req", imem_req, 1);
      chk("t7_addr", imem_addr, 32'h0);
      tick();
      drv(1, 1, 1, 0, 0);
      chk("t7_vld", if_valid, 0);
      tick();
      drv(1, 1, 1, 0, 0);
      chk("t7_vld2", if_valid, 1);
      chk("t7_pc", if_pc, 32'h0);
      chk("t7_inst", if_inst, 32'h5A5A_0000);
      tick();

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC SHALL be declared: default 32'h0000_0000; address of the first fetch after reset.
REQ-002 Parameter NOP_INST SHALL be declared: default 32'h0000_0013 (addi x0,x0,0); instruction driven while no valid instruction is present.
REQ-003 Port clk SHALL be: input, 1 bit; single clock; all state updates on its rising edge.
REQ-004 Port rst_n SHALL be: input, 1 bit; reset, synchronous, active-low.
REQ-005 Port redirect_valid SHALL be: input, 1 bit; taken branch, so refetch from redirect_pc.
REQ-006 Port redirect_pc SHALL be: input, 32 bits; branch target.
REQ-007 Port id_ready SHALL be: input, 1 bit; decode stage accepts if_inst this cycle.
REQ-008 Port imem_req SHALL be: output, 1 bit; fetch request valid.
REQ-009 Port imem_addr SHALL be: output, 32 bits; fetch word address.
REQ-010 Port imem_gnt SHALL be: input, 1 bit; memory accepts the request this cycle.
REQ-011 Port imem_rvalid SHALL be: input, 1 bit; read data valid.
REQ-012 Port imem_rdata SHALL be: input, 32 bits; fetched instruction.
REQ-013 Port if_valid SHALL be: output, 1 bit; if_inst/if_pc hold a live instruction.
REQ-014 Port if_pc SHALL be: output, 32 bits; PC of if_inst.
REQ-015 Port if_inst SHALL be: output, 32 bits; instruction to the decode stage.

Function
REQ-016 The FSM SHALL have states REQ, WAIT and HOLD; at most one memory request SHALL be outstanding.
REQ-017 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal pc; both SHALL stay stable until imem_gnt; on gnt: req_pc<=pc, next state WAIT.
REQ-018 REQ SHALL assert imem_req only when the output slot is empty, or is being consumed (id_ready=1) in the same cycle; otherwise imem_req=0.
REQ-019 In WAIT, imem_req SHALL be 0; on imem_rvalid with drop=0 and the output slot free or consumed, the output regs SHALL load {1, req_pc, imem_rdata}, pc<=req_pc+4 (mod 2^32), and next state SHALL be REQ.
REQ-020 In WAIT, on imem_rvalid with the output slot full and id_ready=0, the response SHALL go to a 1-entry pending buffer, with pc<=req_pc+4 and next state HOLD.
REQ-021 In HOLD, imem_req SHALL be 0; when id_ready=1, the pending entry SHALL move into the output regs next cycle, and next state SHALL be REQ.
REQ-022 The output handshake SHALL work as follows: an instruction is consumed when if_valid && id_ready; if_valid SHALL clear after consumption unless it is refilled in the same cycle.
REQ-023 When if_valid=0, if_inst SHALL be NOP_INST and if_pc SHALL hold its last value.
REQ-024 Redirect SHALL have the highest priority: pc<={redirect_pc[31:2],2'b00}; if_valid and the pending buffer SHALL clear next cycle.
REQ-025 Redirect in REQ without gnt, or in HOLD, SHALL go to REQ with drop=0.
REQ-026 Redirect in REQ together with gnt SHALL go to WAIT with drop=1.
REQ-027 Redirect in WAIT without rvalid SHALL stay in WAIT with drop=1.
REQ-028 Redirect in WAIT together with rvalid SHALL discard the data and go to REQ.
REQ-029 A response arriving with drop=1 SHALL be discarded without changing outputs or pc; it SHALL clear drop, and next state SHALL be REQ.
REQ-030 Minimum fetch latency SHALL be as follows: gnt in cycle N, rvalid in N+1 -> if_valid=1 in N+2; peak throughput SHALL be one instruction per 2 cycles.

Reset
REQ-031 While rst_n=0 at a clock edge, the block SHALL set: state=REQ, pc=RESET_PC, drop=0, pending empty, if_valid=0, if_pc=RESET_PC, if_inst=NOP_INST.
REQ-032 imem_req SHALL be 0 during reset and SHALL be 1 from the first cycle after rst_n rises.
REQ-033 A response arriving in the first cycle after a mid-operation reset SHALL be ignored.

Structure
REQ-034 RESET_PC, NOP_INST and the FSM state encoding SHALL live in a shared package, cpu_pkg.
REQ-035 The output register plus pending entry SHALL be one sub-module, if_skid_buf, with a valid/ready interface.

Verification
REQ-036 Reset with zero-wait memory -> imem_addr sequence 0x0,0x4,0x8; if_pc/if_inst match the memory; if_valid every other cycle.
REQ-037 id_ready=0 for 5 cycles while fetching 0x4 -> no request is issued after the pending entry fills; no instruction is lost or duplicated; order 0x0,0x4,0x8 is preserved.
REQ-038 Redirect to 0x100 while in WAIT for 0x8 -> the 0x8 data is discarded; the next if_pc is 0x100; imem_addr is 0x100.
REQ-039 Redirect to 0x203 together with rvalid -> the data is dropped; the next fetch is 0x200.
REQ-040 pc=0xFFFF_FFFC fetch -> the next imem_addr is 0x0000_0000.
REQ-041 rst_n=0 while in HOLD -> after release, if_valid=0, if_inst=0x0000_0013, and imem_addr=RESET_PC.
